// File: rtl/issue_exec_alu_pipe.sv
// ALU issue/execute stage with a STAGES-deep elastic result pipeline.
// Bubbles collapse forward; flush squashes valid bits but leaves payloads untouched.
module issue_exec_alu_pipe #(
    parameter int WIDTH      = 64,
    parameter int ROBsize    = 8,
    parameter int ROBsizeLog = $clog2(ROBsize + 1),
    parameter int CMD_W      = 10,
    parameter int STAGES     = 2
) (
    input  logic                         clk_i,
    input  logic                         reset_i,
    input  logic                         readyRS_i,
    input  logic [WIDTH-1:0]             reservationStationVal1_i,
    input  logic [WIDTH-1:0]             reservationStationVal2_i,
    input  logic [CMD_W-1:0]             reservationStationCommands_i,
    input  logic [ROBsizeLog-1:0]        reservationStationTag_i,
    output logic                         stallRS_o,
    input  logic                         flush_i,
    input  logic                         canGo_i,
    output logic                         valid_o,
    output logic [WIDTH-1:0]             executeVal_o,
    output logic [ROBsizeLog-1:0]        executeTag_o,
    output logic [CMD_W-1:0]             executeCommands_o,
    output logic [3:0]                   executeFlags_o,
    output logic [$clog2(STAGES+1)-1:0]  occupancy_o
);

    localparam int OCC_W = $clog2(STAGES + 1);

    logic [2:0]        w_op;
    logic              w_arith;
    logic              w_sub;
    logic [WIDTH-1:0]  w_b_eff;
    logic [WIDTH:0]    w_sum;
    logic [WIDTH-1:0]  w_res;
    logic [3:0]        w_flags;
    logic [STAGES-1:0] w_adv;
    logic              w_accept;
    logic [OCC_W-1:0]  w_occ;

    logic [STAGES-1:0]     r_v;
    logic [WIDTH-1:0]      r_val   [STAGES];
    logic [3:0]            r_flags [STAGES];
    logic [ROBsizeLog-1:0] r_tag   [STAGES];
    logic [CMD_W-1:0]      r_cmd   [STAGES];

    // Subtraction shares the adder as A + ~B + 1 so carry/overflow fall out uniformly.
    always_comb begin
        w_op    = reservationStationCommands_i[4:2];
        w_arith = (w_op == 3'b010) || (w_op == 3'b011);
        w_sub   = (w_op == 3'b011);
        w_b_eff = w_sub ? ~reservationStationVal2_i : reservationStationVal2_i;
        w_sum   = {1'b0, reservationStationVal1_i} + {1'b0, w_b_eff}
                + {{WIDTH{1'b0}}, w_sub};
        w_res   = '0;
        case (w_op)
            3'b000:  w_res = reservationStationVal2_i;
            3'b010:  w_res = w_sum[WIDTH-1:0];
            3'b011:  w_res = w_sum[WIDTH-1:0];
            3'b100:  w_res = reservationStationVal1_i & reservationStationVal2_i;
            3'b101:  w_res = reservationStationVal1_i | reservationStationVal2_i;
            3'b110:  w_res = reservationStationVal1_i ^ reservationStationVal2_i;
            default: w_res = '0;
        endcase
        w_flags[3] = w_arith & w_sum[WIDTH];
        w_flags[2] = w_arith
                   & (reservationStationVal1_i[WIDTH-1] == w_b_eff[WIDTH-1])
                   & (w_sum[WIDTH-1] != reservationStationVal1_i[WIDTH-1]);
        w_flags[1] = (w_res == '0);
        w_flags[0] = w_res[WIDTH-1];
    end

    // A stage advances unless it and every stage after it are valid while the output is blocked.
    always_comb begin
        logic all_v;
        all_v = 1'b1;
        w_adv = '0;
        for (int k = STAGES - 1; k >= 0; k--) begin
            all_v    = all_v & r_v[k];
            w_adv[k] = canGo_i | ~all_v;
        end
    end

    assign stallRS_o = ~w_adv[0];
    assign w_accept  = readyRS_i & w_adv[0];

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            r_v <= '0;
            for (int k = 0; k < STAGES; k++) begin
                r_val[k]   <= '0;
                r_flags[k] <= '0;
                r_tag[k]   <= '0;
                r_cmd[k]   <= '0;
            end
        end else begin
            if (w_adv[0]) begin
                r_v[0]     <= w_accept;
                r_val[0]   <= w_res;
                r_flags[0] <= w_flags;
                r_tag[0]   <= reservationStationTag_i;
                r_cmd[0]   <= reservationStationCommands_i;
            end
            for (int k = 1; k < STAGES; k++) begin
                if (w_adv[k]) begin
                    r_v[k]     <= r_v[k-1];
                    r_val[k]   <= r_val[k-1];
                    r_flags[k] <= r_flags[k-1];
                    r_tag[k]   <= r_tag[k-1];
                    r_cmd[k]   <= r_cmd[k-1];
                end
            end
            if (flush_i) begin
                r_v <= '0;
            end
        end
    end

    always_comb begin
        logic [OCC_W-1:0] cnt;
        cnt = '0;
        for (int k = 0; k < STAGES; k++) begin
            cnt = cnt + OCC_W'(r_v[k]);
        end
        w_occ = cnt;
    end

    assign occupancy_o       = w_occ;
    assign valid_o           = r_v[STAGES-1];
    assign executeVal_o      = r_val[STAGES-1];
    assign executeFlags_o    = r_flags[STAGES-1];
    assign executeTag_o      = r_tag[STAGES-1];
    assign executeCommands_o = r_cmd[STAGES-1];

endmodule

// File: tb/tb_issue_exec_alu_pipe.sv
// Scoreboard bench for issue_exec_alu_pipe: expected results are queued at accept
// and compared against the output slot while it is valid.
module tb_issue_exec_alu_pipe;

    localparam int WIDTH   = 64;
    localparam int ROBSZ   = 8;
    localparam int TAG_W   = $clog2(ROBSZ + 1);
    localparam int CMD_W   = 10;
    localparam int STAGES  = 2;
    localparam int OCC_W   = $clog2(STAGES + 1);

    logic               clk_i;
    logic               reset_i;
    logic               readyRS_i;
    logic [WIDTH-1:0]   val1;
    logic [WIDTH-1:0]   val2;
    logic [CMD_W-1:0]   cmd;
    logic [TAG_W-1:0]   tag;
    logic               stallRS_o;
    logic               flush_i;
    logic               canGo_i;
    logic               valid_o;
    logic [WIDTH-1:0]   executeVal_o;
    logic [TAG_W-1:0]   executeTag_o;
    logic [CMD_W-1:0]   executeCommands_o;
    logic [3:0]         executeFlags_o;
    logic [OCC_W-1:0]   occupancy_o;

    issue_exec_alu_pipe #(
        .WIDTH(WIDTH), .ROBsize(ROBSZ), .ROBsizeLog(TAG_W), .CMD_W(CMD_W), .STAGES(STAGES)
    ) dut (
        .clk_i                        (clk_i),
        .reset_i                      (reset_i),
        .readyRS_i                    (readyRS_i),
        .reservationStationVal1_i     (val1),
        .reservationStationVal2_i     (val2),
        .reservationStationCommands_i (cmd),
        .reservationStationTag_i      (tag),
        .stallRS_o                    (stallRS_o),
        .flush_i                      (flush_i),
        .canGo_i                      (canGo_i),
        .valid_o                      (valid_o),
        .executeVal_o                 (executeVal_o),
        .executeTag_o                 (executeTag_o),
        .executeCommands_o            (executeCommands_o),
        .executeFlags_o               (executeFlags_o),
        .occupancy_o                  (occupancy_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [WIDTH-1:0] val;
        logic [3:0]       flags;
        logic [TAG_W-1:0] tag;
        logic [CMD_W-1:0] cmd;
    } exp_t;

    exp_t sb[$];
    int   passed = 0;
    int   total  = 0;

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] want);
        total++;
        if (got === want) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, got, want);
    endtask

    function automatic exp_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                   input logic [CMD_W-1:0] c, input logic [TAG_W-1:0] t);
        exp_t           e;
        logic [WIDTH:0] wide;
        logic [WIDTH-1:0] r;
        logic           cy;
        logic           ov;
        r = '0; cy = 1'b0; ov = 1'b0;
        case (c[4:2])
            3'b000: r = b;
            3'b010: begin
                wide = {1'b0, a} + {1'b0, b};
                r  = wide[WIDTH-1:0];
                cy = wide[WIDTH];
                ov = (a[WIDTH-1] == b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
            end
            3'b011: begin
                r  = a - b;
                cy = (a >= b);
                ov = (a[WIDTH-1] != b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
            end
            3'b100: r = a & b;
            3'b101: r = a | b;
            3'b110: r = a ^ b;
            default: r = '0;
        endcase
        e.val   = r;
        e.flags = {cy, ov, (r == '0), r[WIDTH-1]};
        e.tag   = t;
        e.cmd   = c;
        return e;
    endfunction

    // Scoreboard monitor, mid-cycle: inputs and outputs are stable here.
    always @(negedge clk_i) begin
        if (!reset_i) begin
            sb.delete();
        end else begin
            chk("occ_vs_sb", occupancy_o, sb.size());
            if (flush_i) begin
                sb.delete();
            end else begin
                if (valid_o) begin
                    if (sb.size() == 0) begin
                        chk("spurious_valid", valid_o, 1'b0);
                    end else begin
                        chk("sb_val",   executeVal_o,      sb[0].val);
                        chk("sb_flags", executeFlags_o,    sb[0].flags);
                        chk("sb_tag",   executeTag_o,      sb[0].tag);
                        chk("sb_cmd",   executeCommands_o, sb[0].cmd);
                        if (canGo_i) void'(sb.pop_front());
                    end
                end
                if (readyRS_i && !stallRS_o) sb.push_back(model(val1, val2, cmd, tag));
            end
        end
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic set_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input logic [CMD_W-1:0] c, input logic [TAG_W-1:0] t);
        val1 = a; val2 = b; cmd = c; tag = t;
    endtask

    // Issue one op into an empty, unblocked pipeline and wait for it at the output.
    task automatic single(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input logic [CMD_W-1:0] c, input logic [TAG_W-1:0] t);
        int cyc;
        set_op(a, b, c, t);
        readyRS_i = 1'b1;
        canGo_i   = 1'b1;
        tick();
        readyRS_i = 1'b0;
        cyc = 1;
        while (!valid_o && cyc < 20) begin
            tick();
            cyc++;
        end
        chk("latency", cyc, STAGES);
    endtask

    task automatic drain(input string name);
        int n;
        canGo_i   = 1'b1;
        readyRS_i = 1'b0;
        n = 0;
        while (occupancy_o != 0 && n < 30) begin
            tick();
            n++;
        end
        chk(name, occupancy_o, 0);
        chk({name, "_sb"}, sb.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [WIDTH-1:0] ev;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [127:0]     r128;

        reset_i = 1'b0; readyRS_i = 1'b0; flush_i = 1'b0; canGo_i = 1'b0;
        set_op('0, '0, '0, '0);
        #2;
        chk("rst_valid", valid_o, 0);
        chk("rst_val",   executeVal_o, 0);
        chk("rst_tag",   executeTag_o, 0);
        chk("rst_cmd",   executeCommands_o, 0);
        chk("rst_flags", executeFlags_o, 0);
        chk("rst_occ",   occupancy_o, 0);
        chk("rst_stall", stallRS_o, 0);
        tick(); tick();
        reset_i = 1'b1;
        tick();

        single(64'd15, 64'd3, 10'd10, 4'd3);
        chk("add_val",   executeVal_o, 18);
        chk("add_tag",   executeTag_o, 3);
        chk("add_cmd",   executeCommands_o, 10);
        chk("add_flags", executeFlags_o, 4'b0000);
        tick();

        single(64'd3, 64'd15, 10'd12, 4'd4);
        ev = '0;
        ev = ev - 64'd12;
        chk("sub_val",   executeVal_o, ev);
        chk("sub_flags", executeFlags_o, 4'b0001);
        tick();

        single(64'd5, 64'd5, 10'd12, 4'd5);
        chk("subeq_val",   executeVal_o, 0);
        chk("subeq_flags", executeFlags_o, 4'b1010);
        tick();

        a = {1'b0, {(WIDTH-1){1'b1}}};
        single(a, 64'd1, 10'd10, 4'd6);
        ev = {1'b1, {(WIDTH-1){1'b0}}};
        chk("ovf_val",   executeVal_o, ev);
        chk("ovf_flags", executeFlags_o, 4'b0101);
        tick();
        drain("drain_basic");

        // Backpressure: fill, hold an extra op, then release.
        canGo_i = 1'b0;
        for (int i = 0; i < STAGES; i++) begin
            set_op(64'(i + 10), 64'd1, 10'd10, TAG_W'(i + 1));
            readyRS_i = 1'b1;
            tick();
        end
        readyRS_i = 1'b0;
        @(negedge clk_i);
        chk("bp_full_stall", stallRS_o, 1);
        chk("bp_full_occ",   occupancy_o, STAGES);
        chk("bp_full_valid", valid_o, 1);
        @(posedge clk_i); #1;
        set_op(64'd100, 64'd200, 10'd10, 4'd7);
        readyRS_i = 1'b1;
        repeat (3) tick();
        @(negedge clk_i);
        chk("bp_hold_stall", stallRS_o, 1);
        @(posedge clk_i); #1;
        canGo_i = 1'b1;
        @(negedge clk_i);
        chk("bp_release_stall", stallRS_o, 0);
        @(posedge clk_i); #1;
        readyRS_i = 1'b0;
        drain("bp_drain");

        // Bubble collapse with a blocked output.
        canGo_i = 1'b0;
        set_op(64'd1, 64'd2, 10'd10, 4'd1);
        readyRS_i = 1'b1;
        tick();
        readyRS_i = 1'b0;
        chk("bub_a_stall", stallRS_o, 0);
        chk("bub_a_occ",   occupancy_o, 1);
        tick();
        chk("bub_idle_valid", valid_o, 1);
        chk("bub_idle_stall", stallRS_o, 0);
        set_op(64'd3, 64'd4, 10'd10, 4'd2);
        readyRS_i = 1'b1;
        tick();
        readyRS_i = 1'b0;
        chk("bub_b_occ",   occupancy_o, 2);
        chk("bub_b_stall", stallRS_o, 1);
        chk("bub_b_tag",   executeTag_o, 1);
        drain("bub_drain");

        // Flush a full pipeline together with a same-cycle accept.
        canGo_i = 1'b0;
        for (int i = 0; i < STAGES; i++) begin
            set_op(64'(i), 64'd9, 10'd10, TAG_W'(i + 1));
            readyRS_i = 1'b1;
            tick();
        end
        set_op(64'd77, 64'd1, 10'd10, 4'd5);
        readyRS_i = 1'b1;
        canGo_i   = 1'b1;
        flush_i   = 1'b1;
        tick();
        flush_i   = 1'b0;
        readyRS_i = 1'b0;
        chk("flush_valid", valid_o, 0);
        chk("flush_occ",   occupancy_o, 0);
        repeat (5) tick();
        chk("flush_quiet", valid_o, 0);

        // Asynchronous reset in the middle of a stream.
        canGo_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            set_op(64'(i * 3), 64'd5, 10'd10, TAG_W'(i));
            readyRS_i = 1'b1;
            tick();
        end
        @(negedge clk_i); #1;
        reset_i = 1'b0;
        #1;
        chk("arst_valid", valid_o, 0);
        chk("arst_val",   executeVal_o, 0);
        chk("arst_tag",   executeTag_o, 0);
        chk("arst_cmd",   executeCommands_o, 0);
        chk("arst_flags", executeFlags_o, 0);
        chk("arst_occ",   occupancy_o, 0);
        chk("arst_stall", stallRS_o, 0);
        @(posedge clk_i); #1;
        readyRS_i = 1'b0;
        tick();
        reset_i = 1'b1;
        tick();

        // Random traffic: all ops, random stalls, occasional flush.
        for (int i = 0; i < 400; i++) begin
            r128 = {$urandom, $urandom, $urandom, $urandom};
            a = r128[WIDTH-1:0];
            r128 = {$urandom, $urandom, $urandom, $urandom};
            b = r128[WIDTH-1:0];
            if ($urandom_range(0, 7) == 0) b = a;
            if ($urandom_range(0, 7) == 0) a = {1'b0, {(WIDTH-1){1'b1}}};
            set_op(a, b, CMD_W'($urandom_range(0, (1 << CMD_W) - 1)),
                   TAG_W'($urandom_range(0, ROBSZ)));
            readyRS_i = ($urandom_range(0, 3) != 0);
            canGo_i   = ($urandom_range(0, 2) != 0);
            flush_i   = ($urandom_range(0, 49) == 0);
            tick();
        end
        flush_i = 1'b0;
        drain("rand_drain");
        chk("end_valid", valid_o, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/issue_exec_alu_pipe.md
# issue_exec_alu_pipe

Pipelined, parametrised successor to the combinational ALU issue/execute stage. It sits between a reservation station and the execution decision unit (CDB arbiter). It accepts one ready operation per cycle, computes the ALU result and flags, and carries result, tag and commands through a STAGES-deep elastic register pipeline. It adds backpressure, bubble collapsing, occupancy reporting and a misprediction flush, none of which the single-cycle stage provides.

## Interface
- WIDTH, 64, operand/result width (≥2)
- ROBsize, 8, ROB entries
- ROBsizeLog, $clog2(ROBsize+1), tag width
- CMD_W, 10, command bus width (≥5)
- STAGES, 2, pipeline depth = result latency in cycles (1..4)
- clk_i  in  1  clock; all state on rising edge
- reset_i  in  1  asynchronous, active-low reset
- readyRS_i  in  1  RS presents a valid operation
- reservationStationVal1_i  in  WIDTH  operand A
- reservationStationVal2_i  in  WIDTH  operand B
- reservationStationCommands_i  in  CMD_W  commands; [4:2] = ALU op
- reservationStationTag_i  in  ROBsizeLog  ROB tag
- stallRS_o  out  1  RS must hold its operation this cycle
- flush_i  in  1  squash everything in flight
- canGo_i  in  1  downstream accepts the output this cycle
- valid_o  out  1  output slot holds a result
- executeVal_o  out  WIDTH  result
- executeTag_o  out  ROBsizeLog  tag
- executeCommands_o  out  CMD_W  commands, passed through unchanged
- executeFlags_o  out  4  {carry, overflow, zero, negative} = [3:0]
- occupancy_o  out  $clog2(STAGES+1)  number of valid stages

## Operation
- ALU is combinational at input. Op = commands[4:2].
  - 000: B
  - 010: A+B
  - 011: A−B, computed as A+~B+1
  - 100: A&B
  - 101: A|B
  - 110: A^B
  - 001, 111: result 0
- Flags:
  - negative = result[WIDTH-1]
  - zero = (result==0)
  - carry = carry out of bit WIDTH-1 for 010/011, else 0
  - overflow = signed overflow for 010/011, else 0
- Stage k holds {v[k], val, flags, tag, cmd}. Stage STAGES-1 drives the outputs.
- Advance rules:
  - adv[STAGES-1] = ~v[STAGES-1] | canGo_i
  - adv[k] = ~v[k] | adv[k+1]
  - Bubbles collapse: a valid stage moves forward into an empty or advancing successor.
- Accept = readyRS_i & ~stallRS_o, where stallRS_o = ~adv[0] (combinational).
- On accept, stage 0 loads the ALU output. If stage 0 advances without an accept, v[0] clears.
- Payload registers load only when their stage advances; a held stage keeps all fields stable.
- occupancy_o = popcount(v), registered-state derived.
- flush_i: all v clear at the next edge.
  - Any operation accepted in the same cycle is dropped.
  - canGo_i in the same cycle is a don't-care: the output is discarded.
  - Payloads are not cleared.

## Timing
- Reset (async, reset_i=0): all v=0, all payload registers 0.
  - Outputs: valid_o=0, executeVal_o=0, executeTag_o=0, executeCommands_o=0, executeFlags_o=0, occupancy_o=0.
  - stallRS_o=0 (combinationally, since pipeline empty).
  - Reset mid-operation discards all in-flight work; no partial results.
- Latency: operation accepted at edge N appears with valid_o=1 after edge N+STAGES−1. Equivalently, it is visible STAGES cycles after presentation when unstalled.
- Throughput: 1 op/cycle with canGo_i held high; stallRS_o stays 0.
- Full pipeline with canGo_i=0: stallRS_o=1. The next canGo_i=1 cycle drops stallRS_o the same cycle, so accept and output transfer happen simultaneously.
- valid_o is held with stable payload until canGo_i=1 (no retraction except flush/reset).
- canGo_i with valid_o=0 has no effect.

## Test plan
- Reset then single add: A=15, B=3, cmd=10 (op 010), tag=3, canGo_i=1.
  - Expect valid_o=1 exactly STAGES cycles later.
  - Val=18, tag=3, cmd=10, flags=0000.
- Sub: A=3, B=15, op 011.
  - Expect val=2^WIDTH−12 (0xFFFF…FFF4), negative=1, carry=0, overflow=0, zero=0.
- Sub with A=5, B=5: expect val=0, zero=1, carry=1.
- Add 0x7FFF…F + 1: expect overflow=1, negative=1.
- Backpressure, canGo_i=0:
  - Stream STAGES ops; expect stallRS_o=1 after STAGES accepts, occupancy_o=STAGES.
  - Extra op is held and not lost.
  - Raise canGo_i: expect ops emitted in order, one per cycle, with tags intact.
- Bubble collapse:
  - Accept op, then idle one cycle, then accept op, with canGo_i=0.
  - Expect both packed into the last two stages and stallRS_o=1 only when all STAGES stages are valid.
- Flush with full pipeline plus same-cycle accept:
  - Expect valid_o=0 and occupancy_o=0 next cycle.
  - Expect no flushed tag ever emitted.
  - Async reset asserted mid-stream: outputs 0 immediately, before the next edge.
